// File: rtl/ps2_rx_fifo_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_FILTER_LEN     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 25000;
  localparam int DEF_FIFO_DEPTH     = 8;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO; a push while full is still accepted when a pop frees a slot that cycle.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = PS2_DATA_BITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full | pop_ok);
  assign drop_o  = push_i & ~push_ok;

  assign wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
  assign rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};

  // Gated so the head reads as zero, not stale storage, while empty.
  assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, de-glitch clock, deserialise, check, buffer.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [PS2_DATA_BITS-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0]   clk_sync_q, dat_sync_q;
  logic                     sclk, sdat;
  logic [FW-1:0]            filt_cnt_q, filt_cnt_d;
  logic                     fclk_q, fclk_d, fclk_prev_q;
  logic                     fall;

  ps2_state_e               state_q, state_d;
  logic [2:0]               bitcnt_q, bitcnt_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     tmo_hit;
  logic [PS2_DATA_BITS-1:0] shift_q;
  logic                     par_q;

  logic                     push_q, push_d;
  logic [PS2_DATA_BITS-1:0] push_data_q;
  logic                     frame_set;
  logic                     fifo_empty, fifo_drop;
  logic                     frame_err_q, overflow_q;

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];

  // Filtered clock only follows the synchronised line after FILTER_LEN agreeing samples.
  always_comb begin
    filt_cnt_d = '0;
    fclk_d     = fclk_q;
    if (sclk != fclk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) fclk_d = sclk;
      else                                  filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall = fclk_prev_q & ~fclk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      filt_cnt_q  <= '0;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      filt_cnt_q  <= filt_cnt_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_q;
    end
  end

  assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!sdat) state_d = DATA;
        DATA:    if (bitcnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    push_d    = 1'b0;
    frame_set = 1'b0;
    if (tmo_hit) begin
      frame_set = 1'b1;
    end else if (fall && state_q == STOP) begin
      if (sdat && odd_parity_ok(shift_q, par_q)) push_d    = 1'b1;
      else                                       frame_set = 1'b1;
    end
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    if (state_q == IDLE)             bitcnt_d = '0;
    else if (fall && state_q == DATA) bitcnt_d = bitcnt_q + 1'b1;
    tmo_d = tmo_q + 1'b1;
    if (state_q == IDLE || fall || tmo_hit) tmo_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_q    <= '0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      frame_err_q <= frame_set | (frame_err_q & ~err_clr);
      overflow_q  <= fifo_drop | (overflow_q & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state_q == DATA)   shift_q[bitcnt_q] <= sdat;
    if (fall && state_q == PARITY) par_q <= sdat;
    if (push_d)                    push_data_q <= shift_q;
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (rd_en),
    .head_o      (rd_data),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign rd_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Receive front end for the PS/2 keyboard path. Synchronises and de-glitches the raw `ps2_clk`/`ps2_data` lines, deserialises 11-bit device-to-host frames, checks start, parity and stop bits, and buffers good scan-code bytes in a small show-ahead FIFO. The keyboard status keeper consumes bytes from this block through a valid/read handshake.

## Interface
- `SYNC_STAGES`, 2: flops in each input synchroniser; must be ≥2.
- `FILTER_LEN`, 4: consecutive equal synchronised samples required before the filtered `ps2_clk` changes; must be ≥1.
- `TIMEOUT_CYCLES`, 25000: idle `clk` cycles allowed between falling edges inside a frame. At 100 MHz this is 250 µs.
- `FIFO_DEPTH`, 8: byte entries. Must be a power of 2, ≥2.

- `clk` input 1: system clock; the only clock.
- `reset_n` input 1: asynchronous active-low reset.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `ps2_data` input 1: raw PS/2 data line, asynchronous.
- `rd_en` input 1: pop the FIFO head. Ignored when `rd_valid`=0.
- `err_clr` input 1: clears `frame_err` and `overflow`.
- `rd_data` output 8: FIFO head byte. Only meaningful while `rd_valid`=1.
- `rd_valid` output 1: FIFO not empty.
- `frame_err` output 1: sticky flag. Set on a parity error, stop-bit error or timeout.
- `overflow` output 1: sticky flag. Set when a good byte is dropped because the FIFO is full.

## Operation
- **Reset values:** all outputs 0, FIFO empty, FSM in IDLE, synchroniser and filter flops at 1 (idle line level).
- **Edge detection:** `fclk` is the filtered clock. A falling edge is `fclk` 1→0. On that edge the block samples `sdat`, the synchronised data; there is no separate data filter.
- **FSM states and transitions:**
  - IDLE: on an edge with `sdat`=0, go to DATA with bit count 0. An edge with `sdat`=1 is ignored.
  - DATA: each edge shifts `sdat` into bit[count], LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit. The frame is good only if data XOR parity reduces to 1 (odd parity). Go to STOP.
  - STOP: `sdat`=1 and parity good → push the byte. Otherwise set `frame_err` and drop the byte. Return to IDLE in either case.
- **Timeout:** the counter clears on every edge and in IDLE, and increments every cycle outside IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, the partial frame is discarded and `frame_err` is set.
- **FIFO push:** accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle. Otherwise the byte is dropped and `overflow` is set.
- **FIFO pointers:** read and write pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally. Full means the pointers differ only in the MSB.
- **Show-ahead read:** `rd_data` reflects the head combinationally from the storage array. After a pop, the new head is visible on the next cycle.
- **Push to an empty FIFO with a same-cycle `rd_en`:** `rd_en` is ignored because `rd_valid` was 0. The byte appears on the next cycle.
- **Sticky flags:**
  - If `err_clr` and a new error event occur in the same cycle, the flag ends up set (set wins).
  - `err_clr` does not flush the FIFO or the FSM.
- **Reset mid-frame:** immediate return to reset state. The partial frame is lost and the FIFO is emptied.

## Timing
- From a raw `ps2_clk` falling transition to the edge pulse: `SYNC_STAGES` + `FILTER_LEN` + 1 cycles, provided the line holds stable.
- The push happens on the cycle after the STOP edge pulse. `rd_valid` rises on the cycle after the push.
- Total latency from the raw stop-bit falling edge to `rd_valid`: `SYNC_STAGES` + `FILTER_LEN` + 3 cycles. With defaults this is 9 cycles.
- `rd_en` is sampled on the `clk` rising edge. Back-to-back pops every cycle are supported.
- Glitches shorter than `FILTER_LEN` cycles on `ps2_clk` produce no edge.

## Structure
- Shared package `ps2_pkg`:
  - state enum: IDLE, DATA, PARITY, STOP;
  - `PS2_FRAME_BITS` = 11;
  - `PS2_DATA_BITS` = 8;
  - the default parameter constants.
- Sub-module `ps2_byte_fifo`: parameterised synchronous show-ahead FIFO with push, pop, full, empty and the same-cycle push-on-full-with-pop rule.
- The top level holds the synchronisers, the filter, the FSM and the timeout counter.

## Test plan
- **Valid frame:** frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz → `rd_valid`=1 with `rd_data`=0x1C; `frame_err`=0.
- **Bad parity:** frame 0x1C with parity bit 1 → no push; `frame_err`=1 and stays 1 until an `err_clr` pulse, then 0.
- **Timeout:** send 4 bits of a frame, then hold `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles → `frame_err`=1 and FIFO empty. The next full frame 0xF0 is received correctly.
- **Overflow:** 9 frames 0x01..0x09 with no reads → first 8 are retained and 0x09 is dropped; `overflow`=1. Popping 8 times yields 0x01..0x08 in order, then `rd_valid`=0.
- **Full push with simultaneous pop:** FIFO full with `rd_en`=1 on the push cycle → no overflow; count stays 8 and the new byte sits at the tail.
- **Glitch and reset:** a 2-cycle low pulse on `ps2_clk` → no state change. Asserting `reset_n` low mid-frame → all outputs 0 immediately (asynchronous); the next frame 0x5A is received correctly.
